// File: rtl/spwm_pkg.sv
// ============================================================================
// Module   : spwm_pkg
// Brief    : Shared constants and encodings for the SPWM gate generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spwm_pkg;

    // These defaults also set the LUT-stage SIZE / carrier ratio planning.
    localparam int CARRIER_MAX_DEF = 1250;
    localparam int DEAD_CYCLES_DEF = 10;

    localparam logic [1:0] ST_LOW  = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

`default_nettype wire

// File: rtl/spwm_deadtime.sv
// ============================================================================
// Module   : spwm_deadtime
// Brief    : Complementary gate driver with dead-time insertion; one per leg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spwm_deadtime
    import spwm_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst,
    input  logic enable,
    input  logic raw,
    output logic gate_h,
    output logic gate_l
);

    localparam logic [7:0] DT_LAST = 8'(DEAD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [7:0] dt_cnt_q, dt_cnt_d;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dt_cnt_d = dt_cnt_q;
        if (!enable) begin
            state_d  = ST_DEAD;
            dt_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (raw) begin
                        state_d  = ST_DEAD;
                        target_d = ST_HIGH;
                        dt_cnt_d = 8'd0;
                    end
                end
                ST_HIGH: begin
                    if (!raw) begin
                        state_d  = ST_DEAD;
                        target_d = ST_LOW;
                        dt_cnt_d = 8'd0;
                    end
                end
                default: begin
                    // The exit side follows the live comparator, so a raw pulse
                    // shorter than the window still lands on the correct gate.
                    if (dt_cnt_q == DT_LAST) begin
                        state_d  = raw ? ST_HIGH : ST_LOW;
                        dt_cnt_d = 8'd0;
                    end else begin
                        dt_cnt_d = dt_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= ST_DEAD;
            target_q <= ST_LOW;
            dt_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dt_cnt_q <= dt_cnt_d;
        end
    end

    assign gate_h = (state_q == ST_HIGH);
    assign gate_l = (state_q == ST_LOW);

    a_no_overlap: assert property (@(posedge clk_in) !(gate_h && gate_l));
    a_target_legal: assert property (@(posedge clk_in) disable iff (rst)
        target_q != ST_DEAD);

endmodule

`default_nettype wire

// File: rtl/spwm_gate_gen.sv
// ============================================================================
// Module   : spwm_gate_gen
// Brief    : Triangle-carrier SPWM with regular sampling and dead-time gates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spwm_gate_gen
    import spwm_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int CARRIER_MAX = CARRIER_MAX_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int SAMPLE_BOTH = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sine_ref,
    output logic             gate_h,
    output logic             gate_l,
    output logic [WIDTH-1:0] carrier,
    output logic             sync_out,
    output logic [WIDTH-1:0] ref_held
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(CARRIER_MAX);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] carrier_q, carrier_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] ref_held_q, ref_held_d;
    logic             raw_q, raw_d;

    logic             w_at_valley;
    logic             w_at_peak;
    logic             w_sample;
    logic [WIDTH-1:0] w_clamped;

    assign w_at_valley = (carrier_q == '0);
    assign w_at_peak   = (carrier_q == C_MAX);
    assign w_sample    = w_at_valley || ((SAMPLE_BOTH != 0) && w_at_peak);
    assign w_clamped   = (sine_ref > C_MAX) ? C_MAX : sine_ref;

    always_comb begin
        carrier_d  = carrier_q;
        dir_d      = dir_q;
        ref_held_d = w_sample ? w_clamped : ref_held_q;
        raw_d      = (ref_held_q > carrier_q);
        if (enable) begin
            if (dir_q == DIR_UP) begin
                if (w_at_peak) begin
                    dir_d     = DIR_DOWN;
                    carrier_d = C_MAX - C_ONE;
                end else begin
                    carrier_d = carrier_q + C_ONE;
                end
            end else begin
                if (w_at_valley) begin
                    dir_d     = DIR_UP;
                    carrier_d = C_ONE;
                end else begin
                    carrier_d = carrier_q - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            carrier_q  <= '0;
            dir_q      <= DIR_UP;
            ref_held_q <= '0;
            raw_q      <= 1'b0;
        end else begin
            carrier_q  <= carrier_d;
            dir_q      <= dir_d;
            ref_held_q <= ref_held_d;
            raw_q      <= raw_d;
        end
    end

    spwm_deadtime #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk_in (clk_in),
        .rst    (rst),
        .enable (enable),
        .raw    (raw_q),
        .gate_h (gate_h),
        .gate_l (gate_l)
    );

    assign carrier  = carrier_q;
    assign ref_held = ref_held_q;
    // Gated by rst so the pulse stays low while reset holds the carrier at 0.
    assign sync_out = enable && w_at_valley && !rst;

endmodule

`default_nettype wire

// File: tb/tb_spwm_gate_gen.sv
// ============================================================================
// Module   : tb_spwm_gate_gen
// Brief    : Randomized bench for spwm_gate_gen against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spwm_gate_gen;

    localparam int CM = 1250;
    localparam int DT = 10;

    logic        clk_in   = 1'b0;
    logic        rst      = 1'b1;
    logic        enable   = 1'b0;
    logic [11:0] sine_ref = 12'd0;
    logic        gate_h;
    logic        gate_l;
    logic [11:0] carrier;
    logic        sync_out;
    logic [11:0] ref_held;

    spwm_gate_gen #(
        .WIDTH       (12),
        .CARRIER_MAX (CM),
        .DEAD_CYCLES (DT),
        .SAMPLE_BOTH (1)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .sine_ref (sine_ref),
        .gate_h   (gate_h),
        .gate_l   (gate_l),
        .carrier  (carrier),
        .sync_out (sync_out),
        .ref_held (ref_held)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    endtask

    // Model: k counts enabled cycles since reset, the carrier is a pure
    // function of k; gates follow a "blank for DT cycles, then pick side" rule.
    int k, m_ref, m_raw, m_on, m_side, m_remain;

    function automatic int car_of(input int kk);
        int p;
        p = kk % (2 * CM);
        return (p <= CM) ? p : (2 * CM - p);
    endfunction

    task automatic model_reset();
        k = 0; m_ref = 0; m_raw = 0; m_on = 0; m_side = 0; m_remain = DT;
    endtask

    task automatic model_edge();
        int c, nref, nraw, s;
        c    = car_of(k);
        s    = int'(sine_ref);
        nref = (c == 0 || c == CM) ? ((s > CM) ? CM : s) : m_ref;
        nraw = (m_ref > c) ? 1 : 0;
        if (!enable) begin
            m_on = 0; m_remain = DT;
        end else if (m_on == 0) begin
            m_remain--;
            if (m_remain == 0) begin m_on = 1; m_side = m_raw; end
        end else if (m_raw != m_side) begin
            m_on = 0; m_remain = DT;
        end
        if (enable) k++;
        m_ref = nref;
        m_raw = nraw;
    endtask

    task automatic check_outputs();
        int c;
        c = car_of(k);
        check("carrier",  int'(carrier),  c);
        check("ref_held", int'(ref_held), m_ref);
        check("gate_h",   int'(gate_h),   (m_on != 0 && m_side != 0) ? 1 : 0);
        check("gate_l",   int'(gate_l),   (m_on != 0 && m_side == 0) ? 1 : 0);
        check("sync_out", int'(sync_out), (enable && c == 0) ? 1 : 0);
        check("overlap",  int'(gate_h & gate_l), 0);
    endtask

    task automatic step(input bit en, input int s);
        enable   = en;
        sine_ref = 12'(s);
        #1 check_outputs();
        @(posedge clk_in);
        model_edge();
    endtask

    task automatic cycle(input bit en, input int s);
        @(negedge clk_in);
        step(en, s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        bit en;
        bit did_rst;
        model_reset();
        enable   = 1'b1;
        sine_ref = 12'd700;
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_carrier",  int'(carrier),  0);
        check("rst_ref_held", int'(ref_held), 0);
        check("rst_gate_h",   int'(gate_h),   0);
        check("rst_gate_l",   int'(gate_l),   0);
        check("rst_sync",     int'(sync_out), 0);
        enable = 1'b0;
        @(negedge clk_in);
        rst = 1'b0;
        step(1'b1, 0);

        repeat (5100) cycle(1'b1, 0);
        repeat (5000) cycle(1'b1, 625);
        repeat (5000) cycle(1'b1, 2000);

        for (int i = 0; i < 2500; i++) begin
            if ((k % (2 * CM)) == 500) break;
            cycle(1'b1, 400);
        end
        repeat (2600) cycle(1'b1, 1000);

        for (int i = 0; i < 2500; i++) begin
            if ((k % (2 * CM)) == 700) break;
            cycle(1'b1, 1000);
        end
        #1 check("gate_h_before_stop", int'(gate_h), 1);
        repeat (20) cycle(1'b0, 1000);
        check("carrier_held", int'(carrier), 700);
        repeat (30) cycle(1'b1, 1000);

        did_rst = 1'b0;
        for (int i = 0; i < 25000; i++) begin
            s  = (i % 97 == 0) ? int'($urandom_range(1250, 4095))
                               : int'($urandom_range(389, 1249));
            en = !(i > 0 && (i % 4000) < 12);
            cycle(en, s);
            if (i >= 12000 && !did_rst && m_on != 0 && m_side != 0) begin
                did_rst = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("async_gate_h",  int'(gate_h),  0);
                check("async_gate_l",  int'(gate_l),  0);
                check("async_carrier", int'(carrier), 0);
                model_reset();
                @(posedge clk_in);
                @(negedge clk_in);
                rst = 1'b0;
                step(1'b1, s);
            end
        end
        check("async_reset_done", int'(did_rst), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
